seq_priority_encoder: RTL and testbench

Parametrised, registered successor to the team's one-hot 8-to-3 encoders. It accepts an arbitrary WIDTH-bit request vector through a valid/ready handshake. It then streams out the binary index of every set bit, one index per handshake beat, in priority order. The block sits between interrupt or request aggregation logic and any consumer that services one source index at a time. Unlike a pure one-hot encoder, multi-hot vectors are fully serviced, and all-zero vectors are flagged.

---
 rtl/seq_priority_encoder_pkg.sv | 24 ++
 rtl/seq_priority_encoder_if.sv | 30 +++
 rtl/seq_priority_encoder_prio_index.sv | 38 +++
 rtl/seq_priority_encoder.sv | 87 ++++++++
 tb/tb_seq_priority_encoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seq_priority_encoder_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// The state type, index-width helper and popcount live here.
package seq_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Keeps the index port at least one bit wide even for degenerate widths.
  function automatic int clog2_min1(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic int popcount(input logic [255:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_priority_encoder_if.sv
// Request-in / index-out bus for seq_priority_encoder.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface seq_enc_if
  import seq_enc_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int IDX_W = clog2_min1(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;
  logic [IDX_W:0]   out_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, out_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, out_cnt
  );

endinterface

// File: rtl/seq_priority_encoder_prio_index.sv
// Combinational priority pick: index of the lowest (or highest) set bit
// plus that bit isolated as a one-hot mask.
module prio_index
  import seq_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  localparam int IDX_W    = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);

  // The last match in scan order wins, so scan away from the priority end.
  always_comb begin
    idx    = '0;
    onehot = '0;
    if (LSB_FIRST != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_priority_encoder.sv
// Accepts a request vector and streams the index of every set bit, one per beat,
// in priority order; an all-zero vector yields one beat flagged out_none.
module seq_priority_encoder
  import seq_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  seq_enc_if.slave bus,
  output state_e dbg_state
);

  localparam int IDX_W = clog2_min1(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             none_q, none_d;
  logic [IDX_W:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_onehot;
  logic             out_valid;
  logic             out_last;
  logic             beat;
  logic             in_ready;
  logic             accept;

  prio_index #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_prio_index (
    .vec    (pending_q),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  assign out_valid = (state_q == DRAIN);
  // Exactly one bit left means the isolated bit equals the whole vector.
  assign out_last  = out_valid && (none_q || ((pending_q != '0) && (pending_q == sel_onehot)));
  assign beat      = out_valid && bus.out_ready;
  assign in_ready  = (state_q == IDLE) || (beat && out_last);
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;
    cnt_d     = cnt_q;
    if (beat) begin
      pending_d = pending_q & ~sel_onehot;
      if (out_last) begin
        state_d = IDLE;
      end
    end
    if (accept) begin
      pending_d = bus.in_data;
      cnt_d     = (IDX_W+1)'(popcount(256'(bus.in_data)));
      none_d    = (bus.in_data == '0);
      state_d   = DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = sel_idx;
  assign bus.out_last  = out_last;
  assign bus.out_none  = none_q;
  assign bus.out_cnt   = cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Drives one stimulus stream into an LSB-first and an MSB-first encoder in lockstep
// and checks every beat against per-instance expected queues.
module tb_seq_priority_encoder;
  import seq_enc_pkg::*;

  localparam int W  = 8;
  localparam int EW = 9;  // {idx[2:0], last, none, cnt[3:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic out_ready = 1'b1;
  logic rdy_val = 1'b1;
  logic rnd_ready = 1'b0;
  state_e st_lsb, st_msb;

  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_enc_if #(.WIDTH(W)) if_lsb ();
  seq_enc_if #(.WIDTH(W)) if_msb ();

  assign if_lsb.in_valid  = in_valid;
  assign if_lsb.in_data   = in_data;
  assign if_lsb.out_ready = out_ready;
  assign if_msb.in_valid  = in_valid;
  assign if_msb.in_data   = in_data;
  assign if_msb.out_ready = out_ready;

  seq_priority_encoder #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk (clk), .rst_n (rst_n), .bus (if_lsb.slave), .dbg_state (st_lsb)
  );
  seq_priority_encoder #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk (clk), .rst_n (rst_n), .bus (if_msb.slave), .dbg_state (st_msb)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list set-bit positions, walk them in the required order.
  function automatic void expect_vec(input logic [W-1:0] v);
    int ids[$];
    int n;
    for (int i = 0; i < W; i++) if (v[i]) ids.push_back(i);
    n = ids.size();
    if (n == 0) begin
      exp0_q.push_back({3'd0, 1'b1, 1'b1, 4'd0});
      exp1_q.push_back({3'd0, 1'b1, 1'b1, 4'd0});
    end else begin
      for (int j = 0; j < n; j++) begin
        exp0_q.push_back({3'(ids[j]),       (j == n - 1), 1'b0, 4'(n)});
        exp1_q.push_back({3'(ids[n-1-j]),   (j == n - 1), 1'b0, 4'(n)});
      end
    end
  endfunction

  task automatic mon(input int k, input logic v, input logic ir, input logic [2:0] idx,
                     input logic last, input logic none, input logic [3:0] cnt);
    int sz;
    logic [EW-1:0] front;
    sz = (k == 0) ? exp0_q.size() : exp1_q.size();
    chk($sformatf("out_valid[%0d]", k), 16'(v), 16'(sz != 0));
    chk($sformatf("in_ready[%0d]", k), 16'(ir), 16'((sz == 0) || (sz == 1 && out_ready)));
    if (v && sz != 0) begin
      front = (k == 0) ? exp0_q[0] : exp1_q[0];
      chk($sformatf("beat{idx,last,none,cnt}[%0d]", k), 16'({idx, last, none, cnt}), 16'(front));
      if (out_ready) begin
        if (k == 0) void'(exp0_q.pop_front());
        else        void'(exp1_q.pop_front());
      end
    end
  endtask

  // Monitor: samples on the falling edge, mid-cycle between input updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid_lsb", 16'(if_lsb.out_valid), 16'(0));
      chk("rst_out_valid_msb", 16'(if_msb.out_valid), 16'(0));
    end else begin
      mon(0, if_lsb.out_valid, if_lsb.in_ready, if_lsb.out_idx, if_lsb.out_last,
          if_lsb.out_none, if_lsb.out_cnt);
      mon(1, if_msb.out_valid, if_msb.in_ready, if_msb.out_idx, if_msb.out_last,
          if_msb.out_none, if_msb.out_cnt);
    end
  end

  always @(posedge clk) begin
    #2;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  task automatic send(input logic [W-1:0] v);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = if_lsb.in_ready;
      @(posedge clk);
      if (acc) expect_vec(v);
      #1;
    end
    if (!acc) chk("send_timeout", 16'(0), 16'(1));
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 16'(0), 16'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idx",  16'(if_lsb.out_idx),  16'(0));
    chk("reset_last", 16'(if_lsb.out_last), 16'(0));
    chk("reset_none", 16'(if_lsb.out_none), 16'(0));
    chk("reset_cnt",  16'(if_lsb.out_cnt),  16'(0));
    chk("reset_state", 16'(st_lsb), 16'(IDLE));
    @(posedge clk);
    #1;

    send(8'b1010_0100);
    wait_idle();
    send(8'h00);
    wait_idle();
    chk("idle_after_zero", 16'(st_lsb), 16'(IDLE));

    send(8'h01);
    send(8'h80);
    wait_idle();

    send(8'hFF);
    repeat (3) @(posedge clk);
    #1 rdy_val = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy_val = 1'b1;
    wait_idle();

    send(8'h0F);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    #1 chk("async_reset_valid", 16'(if_lsb.out_valid), 16'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h10);
    wait_idle();

    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int gap;
      int kind;
      logic [W-1:0] v;
      gap  = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      v    = (kind == 0) ? 8'h00 : (kind == 1) ? 8'hFF : W'($urandom);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send(v);
    end
    rnd_ready = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
